// File: rtl/tiny_fpga_pkg.sv
// Shared constants and types for the tiny FPGA configuration loader.
package tiny_fpga_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CHECK,
      COMMIT
   } cfg_state_e;

   function automatic int unsigned nb_bytes(input int unsigned n_tiles,
                                            input int unsigned cfg_bits);
      return (n_tiles * cfg_bits) / 8;
   endfunction

endpackage

// File: rtl/tiny_fpga_cfg_loader.sv
// Byte-serial configuration loader: sync byte, payload, 8-bit additive checksum,
// committed into the active configuration only on a checksum match.
module tiny_fpga_cfg_loader
   import tiny_fpga_pkg::*;
#(
   parameter int unsigned N_TILES  = 4,
   parameter int unsigned CFG_BITS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic [7:0]                   din,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         cfg_clear,
   output logic [N_TILES*CFG_BITS-1:0]  cfg_out,
   output logic                         cfg_valid,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned NB    = nb_bytes(N_TILES, CFG_BITS);
   localparam int unsigned CW    = N_TILES * CFG_BITS;
   localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

   cfg_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [CW-1:0]     shadow_q, shadow_d;
   logic [CW-1:0]     cfg_q, cfg_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              accept;

   assign din_ready = ena && (state_q != COMMIT);
   assign accept    = din_valid && din_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      shadow_d    = shadow_q;
      cfg_d       = cfg_q;
      cfg_valid_d = cfg_valid_q;
      err_d       = err_q;

      if (!ena) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept && din == SYNC_BYTE) begin
                  state_d = LOAD;
                  cnt_d   = '0;
                  sum_d   = '0;
                  err_d   = 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  shadow_d[cnt_q*8 +: 8] = din;
                  sum_d = sum_q + din;
                  if (cnt_q == LAST_CNT) begin
                     state_d = CHECK;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  if (din == sum_q) begin
                     state_d = COMMIT;
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end
            end
            COMMIT: begin
               cfg_d       = shadow_q;
               cfg_valid_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Clear wins over a same-cycle commit or sync acceptance.
      if (cfg_clear) begin
         cfg_d       = '0;
         cfg_valid_d = 1'b0;
         err_d       = 1'b0;
         state_d     = IDLE;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_q       <= '0;
         shadow_q    <= '0;
         cfg_q       <= '0;
         cfg_valid_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         shadow_q    <= shadow_d;
         cfg_q       <= cfg_d;
         cfg_valid_q <= cfg_valid_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign cfg_out   = cfg_q;
   assign cfg_valid = cfg_valid_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: doc/tiny_fpga_cfg_loader.md
# tiny_fpga_cfg_loader

Byte-serial configuration loader for the tiny FPGA fabric. It receives a framed configuration stream (sync byte, payload, checksum) over the 8-bit dedicated input path, assembles it in a shadow register, and commits it to the fabric's active configuration only when the checksum matches. It sits between the top-level `tt_um_tiny_fpga` pin interface and the tile array. It replaces ad-hoc per-pin configuration with a fabric-size-independent, integrity-checked load path.

## Interface
Parameters:
- `N_TILES`, 4, number of fabric tiles (≥1)
- `CFG_BITS`, 16, configuration bits per tile; must be a multiple of 8
- Derived: `NB = N_TILES*CFG_BITS/8` payload bytes; `CW = N_TILES*CFG_BITS` config width

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ena`  in  1  design enable; low aborts any frame in progress
- `din`  in  8  stream byte
- `din_valid`  in  1  `din` is valid this cycle
- `din_ready`  out  1  loader accepts `din` this cycle
- `cfg_clear`  in  1  drop active configuration
- `cfg_out`  out  CW  active configuration; payload byte k drives bits [8k+7:8k]
- `cfg_valid`  out  1  `cfg_out` holds a committed, checksum-verified frame
- `busy`  out  1  frame in progress (LOAD, CHECK, COMMIT)
- `err`  out  1  sticky checksum-failure flag

## Operation
- Byte is accepted on an edge where `din_valid && din_ready && ena`.
- `SYNC_BYTE = 8'hA5`.
- IDLE: accepted byte == `SYNC_BYTE` → LOAD, clear byte counter and sum, clear `err`. Other bytes are ignored.
- LOAD: accepted byte k (0..NB-1) → shadow[8k+7:8k]. `sum <= sum + byte`, mod 256. After byte NB-1 → CHECK. A byte equal to `SYNC_BYTE` inside the payload is treated as data.
- CHECK: accepted byte == `sum` → COMMIT. Mismatch → IDLE, `err <= 1`, shadow discarded, `cfg_out`/`cfg_valid` unchanged.
- COMMIT: lasts exactly one cycle with `din_ready = 0`. `cfg_out <= shadow`, `cfg_valid <= 1`, then → IDLE.
- `din_ready`: 1 in IDLE, LOAD and CHECK; 0 in COMMIT; 0 whenever `ena = 0`.
- `ena` low in LOAD/CHECK/COMMIT → IDLE next edge. Frame is discarded, no commit, `err` unchanged.
- `cfg_clear` (any state) → `cfg_out <= 0`, `cfg_valid <= 0`, `err <= 0`, FSM → IDLE. It overrides a same-cycle COMMIT and a same-cycle sync acceptance.
- A new frame over a valid configuration leaves the old `cfg_out` and `cfg_valid = 1` in place until its own COMMIT.

## Timing
- Reset (`rst_n = 0` at an edge): state IDLE, `cfg_out = 0`, `cfg_valid = 0`, `err = 0`, `busy = 0`, counter and sum = 0. After reset `din_ready = ena`. Reset mid-frame discards the shadow.
- All outputs are registered except `din_ready`, which is combinational from state and `ena`.
- Minimum frame is NB+2 accepted bytes. Back-to-back frames lose one cycle (COMMIT).
- Checksum byte accepted on edge E → COMMIT during cycle E..E+1 → `cfg_out`/`cfg_valid` update on edge E+1.
- Mismatch: `err` is high from edge E; `busy` is low from edge E.
- `busy` rises on the sync-accept edge and falls on the edge leaving COMMIT or CHECK.
- No timeout: the FSM waits indefinitely in LOAD/CHECK while `din_valid = 0`.

## Structure
- Package `tiny_fpga_pkg`: `SYNC_BYTE`, state enum `cfg_state_e {IDLE, LOAD, CHECK, COMMIT}`, helper function for NB.
- Single module, no sub-module. Counter width is `$clog2(NB)` (minimum 1). The shadow and active registers are both CW wide.

## Test plan
All scenarios use N_TILES=2, CFG_BITS=16 (NB=4).
- Good frame: A5,11,22,33,44,AA → `cfg_out = 32'h44332211` and `cfg_valid = 1` one edge after AA; `err = 0`; `din_ready` low for exactly one cycle.
- Bad checksum: A5,11,22,33,44,AB → `err = 1`, `cfg_valid` and `cfg_out` unchanged. Then a good frame with payload 01,02,03,04 and checksum 0A → `err` clears on its sync byte; `cfg_out = 32'h04030201`.
- Noise and gaps: bytes 00,FF before A5, and `din_valid` gaps mid-payload → noise ignored, frame commits correctly. A5 as a payload byte is stored as data (payload A5,00,00,00 with checksum A5 → `cfg_out = 32'h000000A5`).
- Abort: drop `ena` after two payload bytes → `busy = 0` next edge, no commit; a subsequent full frame commits normally.
- `cfg_clear` on the same cycle as COMMIT → `cfg_valid = 0`, `cfg_out = 0`, state IDLE.
- Reset mid-LOAD → all outputs 0; next frame loads from byte 0.
